fpga_receiver: RTL
==================

Name: fpga_receiver

Overview:
- Serial-link receiving end for the FPGA-to-FPGA byte transfer.
- Answers the peer transmitter's request with an acknowledge, shifts in DATA_WIDTH serial bits MSB-first, waits for the transmitter's finish strobe, then presents the byte in parallel with a one-cycle valid pulse.
- Sits between the inter-board pins and local consumer logic; detects aborted or stalled transfers.

Parameters:
- DATA_WIDTH, 8, bits per transfer; also the width of dataOut.
- FIN_TIMEOUT, 16, clock cycles allowed in WAIT_FIN before the transfer is aborted; legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- sendToOther  input  1  transfer request from the remote transmitter; level, held high for the whole transfer.
- dataIn  input  1  serial data bit from the remote transmitter, MSB first.
- finish  input  1  remote transmitter's end-of-byte strobe.
- acknowledge  output  1  request accepted; the remote side starts shifting after seeing it.
- received  output  1  end-of-byte acknowledged to the remote side; held until sendToOther falls.
- dataOut  output  DATA_WIDTH  last successfully received byte.
- dataValid  output  1  one-cycle pulse when dataOut is updated.
- error  output  1  one-cycle pulse on an aborted transfer.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - acknowledge, received, dataValid, error, busy = 0.
  - dataOut, shift register, bit counter, timeout counter = 0.
- All inputs are used as sampled on the rising edge; no input synchronizers inside this block.
- States: IDLE, ACK, RECV, WAIT_FIN, DONE.
- IDLE: if sendToOther=1 -> ACK. Otherwise stay.
- ACK:
  - acknowledge=1 for exactly this one cycle.
  - Bit counter cleared; next state RECV unconditionally.
- RECV:
  - Each edge: shift register <= {shreg[DATA_WIDTH-2:0], dataIn}; bit counter +1.
  - The edge on which the counter reaches DATA_WIDTH-1 captures the last bit -> WAIT_FIN, timeout counter cleared.
  - Exactly DATA_WIDTH bits, sampled on DATA_WIDTH consecutive edges; the first sample is taken on the first edge in RECV.
- WAIT_FIN:
  - finish=1 -> DONE. On that edge dataOut <= shift register, and dataValid=1 during the next cycle only.
  - Otherwise the timeout counter increments. When it reaches FIN_TIMEOUT -> IDLE with error=1 for one cycle; dataOut is unchanged.
- DONE:
  - received=1 while in DONE.
  - sendToOther=0 -> IDLE; received drops the cycle IDLE is entered.
  - finish is ignored in DONE.
- Abort: sendToOther=0 while in ACK, RECV or WAIT_FIN -> IDLE next edge.
  - error pulses one cycle; no dataValid; dataOut unchanged.
  - Abort takes priority over finish and over the timeout when they occur on the same edge.
- finish=1 seen in ACK or RECV (early finish) is treated as abort: error pulse, -> IDLE.
  - If sendToOther=0 on the same edge, it is the same abort: one error pulse only.
- No back-to-back re-trigger: a new transfer needs sendToOther to be low for at least one edge (IDLE) first.
- dataValid and error are never high in the same cycle.
- Reset asserted mid-transfer: immediate return to the reset values; a partial byte is discarded.
- Minimum transfer length from request edge to dataValid: 1 (IDLE->ACK) + 1 (ACK) + DATA_WIDTH (RECV) + 1 (finish) = DATA_WIDTH+3 edges.

Test Plan:
- Nominal byte:
  - Stimulus: raise sendToOther; after acknowledge, drive 1,0,1,0,0,1,0,1 on consecutive edges; finish=1 one cycle later.
  - Required: dataOut=8'hA5, one dataValid pulse, received high until sendToOther drops, then busy=0.
- Back-to-back transfers:
  - Stimulus: send 8'h3C, drop sendToOther for 1 cycle, then send 8'hFF.
  - Required: two dataValid pulses, dataOut=8'h3C then 8'hFF, error never asserted.
- Finish timeout:
  - Stimulus: send 8 bits of 8'h81 and never raise finish.
  - Required: error pulse exactly FIN_TIMEOUT=16 cycles after entering WAIT_FIN; dataOut keeps its previous value; state returns to IDLE.
- Mid-byte abort:
  - Stimulus: drop sendToOther after 4 bits.
  - Required: one error pulse, no dataValid, busy=0 next cycle. The next full transfer of 8'h5A is received correctly.
- Early finish:
  - Stimulus: finish=1 on the 3rd bit of RECV.
  - Required: error pulse, no dataValid, return to IDLE.
- Async reset mid-transfer:
  - Stimulus: reset=0 between clock edges during RECV.
  - Required: all outputs 0 immediately, without waiting for a clock edge; after release, a fresh transfer of 8'hC3 succeeds.

Source files
------------

// File: rtl/fpga_receiver_if.sv
// Inter-board serial link between the remote transmitter and the local
// receiver, plus the parallel result handed to local consumer logic.
// master: remote transmitter / consumer side. slave: fpga_receiver.
interface fpga_receiver_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  sendToOther;
    logic                  dataIn;
    logic                  finish;
    logic                  acknowledge;
    logic                  received;
    logic [DATA_WIDTH-1:0] dataOut;
    logic                  dataValid;
    logic                  error;
    logic                  busy;

    modport master (
        output sendToOther, dataIn, finish,
        input  acknowledge, received, dataOut, dataValid, error, busy
    );

    modport slave (
        input  sendToOther, dataIn, finish,
        output acknowledge, received, dataOut, dataValid, error, busy
    );
endinterface

// File: rtl/fpga_receiver.sv
// Receiving end of the FPGA-to-FPGA byte link. Acknowledges a request,
// shifts in DATA_WIDTH bits MSB-first, waits for the finish strobe and
// publishes the byte with a one-cycle dataValid pulse. Aborted, stalled or
// prematurely finished transfers produce a one-cycle error pulse instead.
module fpga_receiver #(
    parameter int DATA_WIDTH  = 8,   // bits per transfer, must be >= 2
    parameter int FIN_TIMEOUT = 16   // WAIT_FIN cycles before abort, 1..255
) (
    input logic           clk,
    input logic           reset,     // asynchronous, active-low
    fpga_receiver_if.slave link
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam int TMO_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        ACK,
        RECV,
        WAIT_FIN,
        DONE
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_q, valid_d;
    logic                  error_q, error_d;
    // Previous sampled request level: a new transfer starts only on a
    // low-to-high request, so a request left high after an abort or a
    // timeout cannot re-trigger the receiver.
    logic                  send_prev_q;

    // Early finish and a dropped request are the same abort condition.
    logic abort_req;
    assign abort_req = link.finish || !link.sendToOther;

    // State and datapath registers; reset discards any partial byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
            send_prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register sees pre-edge values.
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            error_q     <= error_d;
            send_prev_q <= link.sendToOther;
        end
    end

    // Next-state and datapath updates; abort outranks finish and timeout.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latch).
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        error_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (link.sendToOther && !send_prev_q) begin
                    state_d = ACK;
                end
            end

            ACK: begin
                bit_cnt_d = '0;
                if (abort_req) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                end else begin
                    state_d = RECV;
                end
            end

            RECV: begin
                if (abort_req) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                end else begin
                    shreg_d   = {shreg_q[DATA_WIDTH-2:0], link.dataIn};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    // This edge samples the last bit.
                    if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                        state_d   = WAIT_FIN;
                        tmo_cnt_d = '0;
                    end
                end
            end

            WAIT_FIN: begin
                if (!link.sendToOther) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                end else if (link.finish) begin
                    state_d    = DONE;
                    data_out_d = shreg_q;
                    valid_d    = 1'b1;
                end else if (tmo_cnt_q == TMO_W'(FIN_TIMEOUT - 1)) begin
                    // The increment on this edge would reach FIN_TIMEOUT.
                    state_d = IDLE;
                    error_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end

            DONE: begin
                if (!link.sendToOther) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign link.acknowledge = (state_q == ACK);
    assign link.received    = (state_q == DONE);
    assign link.busy        = (state_q != IDLE);
    assign link.dataOut     = data_out_q;
    assign link.dataValid   = valid_q;
    assign link.error       = error_q;

endmodule
